// File: rtl/hera_pkg.sv
// +----------------------------------------------------------------------------+
// | hera_pkg : shared HERA types and constants (FSM encoding, ISA widths)      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package hera_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } hera_state_t;

  localparam logic [15:0] HERA_HALT    = 16'h0000;
  localparam int          HERA_IMEM_AW = 10;
  localparam int          HERA_IW      = 16;

endpackage

`default_nettype wire

// File: rtl/edge_rise.sv
// +----------------------------------------------------------------------------+
// | edge_rise : registered rising-edge detector with programmable reset value  |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module edge_rise #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= RST_VAL;
    else        r_prev <= d;
  end

  assign rise = d & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/hera_imem_arbiter.sv
// +----------------------------------------------------------------------------+
// | hera_imem_arbiter : shares the instruction RAM between loader and fetch,   |
// |                     holding the CPU in reset while a program loads         |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module hera_imem_arbiter
  import hera_pkg::*;
#(
  parameter int                ADDR_W   = HERA_IMEM_AW,
  parameter int                DATA_W   = HERA_IW,
  parameter logic [DATA_W-1:0] END_WORD = DATA_W'(HERA_HALT),
  parameter int                RST_HOLD = 4
) (
  input  logic              clk_48,
  input  logic              rst_,
  input  logic              ld_wren,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              reload,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_rst_,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W:0]   words,
  output logic              ovf,
  output logic [1:0]        state
);

  localparam logic [ADDR_W:0] c_full      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]      c_hold_last = 4'(RST_HOLD - 1);

  hera_state_t       r_state, w_state_nxt;
  logic              r_cpu_rst_;
  logic              r_ram_wren, w_ram_wren;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata;
  logic [ADDR_W:0]   r_words, w_words, w_words_inc;
  logic              r_ovf, w_ovf;
  logic [3:0]        r_hold_cnt, w_hold_cnt;
  logic              r_rd_p1, w_rd_p1, r_rd_p2;
  logic              r_cpu_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              w_ld_rise;

  // Previous sample resets high so a strobe already asserted at reset release is not an edge.
  edge_rise #(.RST_VAL(1'b1)) u_ld_edge (
    .clk   (clk_48),
    .rst_n (rst_),
    .d     (ld_wren),
    .rise  (w_ld_rise)
  );

  always_ff @(posedge clk_48 or negedge rst_) begin
    if (!rst_) begin
      r_state     <= LOAD;
      r_cpu_rst_  <= 1'b0;
      r_ram_wren  <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_words     <= '0;
      r_ovf       <= 1'b0;
      r_hold_cnt  <= '0;
      r_rd_p1     <= 1'b0;
      r_rd_p2     <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_rst_  <= (w_state_nxt == RUN);
      r_ram_wren  <= w_ram_wren;
      r_ram_addr  <= w_ram_addr;
      r_ram_wdata <= w_ram_wdata;
      r_words     <= w_words;
      r_ovf       <= w_ovf;
      r_hold_cnt  <= w_hold_cnt;
      r_rd_p1     <= w_rd_p1;
      r_rd_p2     <= r_rd_p1;
      r_cpu_ack   <= r_rd_p2;
      if (r_rd_p2) r_cpu_rdata <= ram_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ram_wren  = 1'b0;
    w_ram_addr  = r_ram_addr;
    w_ram_wdata = r_ram_wdata;
    w_words     = r_words;
    w_ovf       = r_ovf;
    w_hold_cnt  = r_hold_cnt;
    w_rd_p1     = 1'b0;
    w_words_inc = (r_words == c_full) ? r_words : r_words + 1'b1;

    case (r_state)
      LOAD: begin
        if (w_ld_rise) begin
          w_ram_wren  = 1'b1;
          w_ram_addr  = ld_addr;
          w_ram_wdata = ld_data;
          w_words     = w_words_inc;
          // Terminator takes priority over the overflow flag.
          if (ld_data == END_WORD) begin
            w_state_nxt = HOLD;
            w_hold_cnt  = '0;
          end else if (w_words_inc == c_full) begin
            w_ovf       = 1'b1;
            w_state_nxt = HOLD;
            w_hold_cnt  = '0;
          end
        end
      end
      HOLD: begin
        if (r_hold_cnt == c_hold_last) begin
          w_state_nxt = RUN;
          w_hold_cnt  = '0;
        end else begin
          w_hold_cnt = r_hold_cnt + 4'd1;
        end
      end
      RUN: begin
        // Reads already in the pipeline complete; a request alongside reload is dropped.
        if (reload) begin
          w_state_nxt = LOAD;
          w_words     = '0;
          w_ovf       = 1'b0;
        end else if (cpu_req) begin
          w_ram_addr = cpu_addr;
          w_rd_p1    = 1'b1;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_rst_  = r_cpu_rst_;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_wren  = r_ram_wren;
  assign words     = r_words;
  assign ovf       = r_ovf;
  assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_hera_imem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_hera_imem_arbiter : directed self-checking bench with a behavioural RAM |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hera_imem_arbiter;

  logic        clk_48 = 1'b0;
  logic        rst_   = 1'b0;
  logic        ld_wren = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        reload  = 1'b0;
  logic        cpu_req = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_rst_;
  logic [9:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_wren;
  logic [15:0] ram_rdata = '0;
  logic [10:0] words;
  logic        ovf;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int wr_base;

  logic [15:0] mem [0:1023];

  always #5 clk_48 = ~clk_48;

  hera_imem_arbiter dut (
    .clk_48    (clk_48),
    .rst_      (rst_),
    .ld_wren   (ld_wren),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .reload    (reload),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_rst_  (cpu_rst_),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren),
    .ram_rdata (ram_rdata),
    .words     (words),
    .ovf       (ovf),
    .state     (state)
  );

  // Single-port RAM with registered address and one-cycle read latency.
  always @(posedge clk_48) begin
    if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    cpu_req = 1'b0;
    reload  = 1'b0;
    rst_    = 1'b0;
    repeat (2) @(posedge clk_48);
    #1 rst_ = 1'b1;
  endtask

  task automatic ld_word(input logic [9:0] a, input logic [15:0] d, input int hold);
    ld_addr = a;
    ld_data = d;
    ld_wren = 1'b1;
    repeat (hold) @(posedge clk_48);
    #1 ld_wren = 1'b0;
    @(posedge clk_48); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hFFFF;
    do_reset();
    @(posedge clk_48); #1;
    check("rst_state", state, 0);
    check("rst_cpu_rst", cpu_rst_, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_words", words, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ack", cpu_ack, 0);

    // Three-word program, strobes held high for 20 cycles.
    wr_base = wr_cnt;
    ld_word(10'd0, 16'h1234, 20);
    ld_word(10'd1, 16'hABCD, 20);
    ld_addr = 10'd2; ld_data = 16'h0000; ld_wren = 1'b1;
    @(posedge clk_48); #1;
    check("term_wren", ram_wren, 1);
    check("term_addr", ram_addr, 2);
    check("term_wdata", ram_wdata, 16'h0000);
    check("term_state", state, 1);
    check("term_words", words, 3);
    repeat (3) @(posedge clk_48); #1;
    check("hold_state", state, 1);
    check("hold_cpu_rst", cpu_rst_, 0);
    @(posedge clk_48); #1;
    check("run_state", state, 2);
    check("run_cpu_rst", cpu_rst_, 1);
    repeat (15) @(posedge clk_48);
    #1 ld_wren = 1'b0;
    @(posedge clk_48); #1;
    check("load3_pulses", wr_cnt - wr_base, 3);
    check("run_words", words, 3);

    // Back-to-back fetches at 0,1,2.
    cpu_req = 1'b1; cpu_addr = 10'd0;
    @(posedge clk_48); #1;
    cpu_addr = 10'd1;
    check("rd_ack_m0", cpu_ack, 0);
    @(posedge clk_48); #1;
    cpu_addr = 10'd2;
    check("rd_ack_m1", cpu_ack, 0);
    @(posedge clk_48); #1;
    cpu_req = 1'b0;
    check("rd0_ack", cpu_ack, 1);
    check("rd0_data", cpu_rdata, 16'h1234);
    @(posedge clk_48); #1;
    check("rd1_ack", cpu_ack, 1);
    check("rd1_data", cpu_rdata, 16'hABCD);
    @(posedge clk_48); #1;
    check("rd2_ack", cpu_ack, 1);
    check("rd2_data", cpu_rdata, 16'h0000);
    @(posedge clk_48); #1;
    check("rd_ack_end", cpu_ack, 0);

    // Reload one cycle after a fetch, with a second fetch alongside reload.
    cpu_req = 1'b1; cpu_addr = 10'd1;
    @(posedge clk_48); #1;
    cpu_addr = 10'd0; reload = 1'b1;
    @(posedge clk_48); #1;
    cpu_req = 1'b0; reload = 1'b0;
    check("rl_state", state, 0);
    check("rl_cpu_rst", cpu_rst_, 0);
    check("rl_words", words, 0);
    check("rl_ram_addr", ram_addr, 1);
    @(posedge clk_48); #1;
    check("rl_ack", cpu_ack, 1);
    check("rl_data", cpu_rdata, 16'hABCD);
    @(posedge clk_48); #1;
    check("rl_no_ack1", cpu_ack, 0);
    @(posedge clk_48); #1;
    check("rl_no_ack2", cpu_ack, 0);

    // Strobe already high at reset release is ignored.
    ld_wren = 1'b1;
    do_reset();
    wr_base = wr_cnt;
    repeat (5) @(posedge clk_48); #1;
    check("lvl_no_write", wr_cnt - wr_base, 0);
    check("lvl_words", words, 0);
    ld_wren = 1'b0;
    @(posedge clk_48); #1;
    for (int i = 0; i < 5; i++) ld_word(10'(10 + i), 16'(16'h0100 + i), 3);
    check("five_pulses", wr_cnt - wr_base, 5);
    check("five_words", words, 5);
    check("five_state", state, 0);

    // Fill the whole RAM without a terminator.
    do_reset();
    @(posedge clk_48); #1;
    wr_base = wr_cnt;
    for (int i = 0; i < 1024; i++) begin
      ld_word(10'(i), 16'(i + 1), 1);
      if (i == 1022) begin
        check("pre_ovf", ovf, 0);
        check("pre_ovf_words", words, 1023);
        check("pre_ovf_state", state, 0);
      end
    end
    check("ovf_flag", ovf, 1);
    check("ovf_words", words, 1024);
    check("ovf_state", state, 1);
    check("ovf_pulses", wr_cnt - wr_base, 1024);
    repeat (2) @(posedge clk_48); #1;
    check("ovf_hold", state, 1);
    @(posedge clk_48); #1;
    check("ovf_run", state, 2);
    ld_word(10'd0, 16'h0077, 1);
    check("ovf_no_write", wr_cnt - wr_base, 1024);
    check("ovf_words_sat", words, 1024);
    cpu_req = 1'b1; cpu_addr = 10'd1023;
    @(posedge clk_48); #1;
    cpu_addr = 10'd0;
    @(posedge clk_48); #1;
    cpu_req = 1'b0;
    @(posedge clk_48); #1;
    check("ovf_rd_last", cpu_rdata, 16'h0400);
    @(posedge clk_48); #1;
    check("ovf_rd_first", cpu_rdata, 16'h0001);

    // Asynchronous reset while a terminator is being written during HOLD.
    do_reset();
    @(posedge clk_48); #1;
    ld_word(10'd7, 16'h5555, 1);
    ld_addr = 10'd8; ld_data = 16'h0000; ld_wren = 1'b1;
    @(posedge clk_48); #3;
    check("pre_rst_wren", ram_wren, 1);
    check("pre_rst_state", state, 1);
    check("pre_rst_words", words, 2);
    rst_ = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_wren", ram_wren, 0);
    check("arst_addr", ram_addr, 0);
    check("arst_wdata", ram_wdata, 0);
    check("arst_words", words, 0);
    check("arst_cpu_rst", cpu_rst_, 0);
    check("arst_ack", cpu_ack, 0);
    check("arst_rdata", cpu_rdata, 0);
    check("arst_ovf", ovf, 0);
    ld_wren = 1'b0;
    #1 rst_ = 1'b1;
    @(posedge clk_48); #1;
    check("post_rst_state", state, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
